frame_tx_arbiter: RTL and testbench
===================================

Name: frame_tx_arbiter

Overview:
Shares one byte-wide UART transmit path between two frame requesters (REQ0 = parser echo, REQ1 = status/diagnostic source).
- Grants one requester per frame and latches its cmd + 64-bit payload.
- Serialises the 13-byte frame: 0x52, 0x0D, cmd, 8 data bytes MSB first, check, 0x9A.
- Frame format is the one the receive-side parser accepts. Check byte makes the 8-bit sum of all 13 bytes equal 0xFF.

Parameters:
HEADER, 8'h52, frame start byte
LENGTH, 8'h0D, length byte (total frame bytes = 13)
TAIL, 8'h9A, frame end byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  2  per-requester frame request, level; held until gnt
cmd0  in  8  REQ0 command byte
data0  in  64  REQ0 payload; [63:56] sent first
cmd1  in  8  REQ1 command byte
data1  in  64  REQ1 payload
gnt  out  2  one-hot, one-cycle pulse: payload latched
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte (byte transfers on valid&&ready)
busy  out  1  frame in progress (HDR..TAIL)
done  out  1  one-cycle pulse after TAIL accepted
done_id  out  1  requester index of finished frame, valid with done

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high. Reset values:
  - gnt=0, tx_valid=0, tx_data=0, busy=0, done=0, done_id=0.
  - state=IDLE, last=1 (so REQ0 wins the first tie), sum=0, byte counter=0.
- State sequence: IDLE, HDR, LEN, CMD, DATA, CHK, TAIL, then back to IDLE.
- IDLE, req==0: no action.
- IDLE, req!=0:
  - Pick winner w: the only active bit; or, if both active, w = ~last.
  - Latch cmd_w/data_w, set last=w, pulse gnt[w] for one cycle.
  - Load tx_data=HEADER, tx_valid=1, busy=1, sum=0; go HDR.
  - gnt appears 1 cycle after req is sampled.
- Requesters must deassert req in the cycle after gnt is high. A req still high when IDLE is re-entered counts as a new request.
- Byte advance rule: in HDR..TAIL, a byte transfers when tx_valid && tx_ready.
  - On transfer: sum <= sum + tx_data (mod 256), and tx_data is loaded with the next byte.
  - tx_valid stays high between bytes; there is no bubble cycle.
  - If tx_ready is low, tx_data and tx_valid hold stable.
- Byte order:
  - HDR sends HEADER, LEN sends LENGTH, CMD sends the latched cmd.
  - DATA sends 8 bytes via a 3-bit counter; byte k = data[63-8k -: 8]. The counter wraps 7 to 0 when leaving DATA.
  - CHK sends check = 8'hFF - (sum + TAIL), where sum covers HEADER..data7.
  - TAIL sends TAIL.
- Frame end: on TAIL transfer, tx_valid=0, busy=0, done=1 and done_id=w for one cycle; go IDLE.
  - The earliest next gnt is 1 cycle after done (IDLE samples req).
  - Minimum frame time is 14 cycles from gnt to the next gnt.
- During a frame, req is ignored: no gnt, and latched payload is unaffected by changes on cmdX/dataX.
- Reset mid-frame: the frame is aborted. tx_valid drops on the reset edge with no TAIL sent, and done does not pulse.
- All arithmetic is 8-bit wrap-around.

Optional Feature:
FRAME_ARB_FIXED_PRIO_EN
- Defined: REQ0 always wins simultaneous requests; last is not used for arbitration (still updated).
- Undefined (default): round-robin as above.

Decomposition:
- Shared package (frame_pkg) holds: HEADER/LENGTH/TAIL constants, PAYLOAD_BYTES=8, FRAME_BYTES=13, and a state enum. The receive-side parser uses the same package.
- One natural sub-module: frame_serializer. It takes the latched cmd/data, runs the byte counter and checksum, and drives tx_valid/tx_ready.
- The arbiter top holds req/gnt, last, and done logic.

Test Plan:
- Single frame: req=01, cmd0=01, data0=0102030405060708, tx_ready=1.
  - gnt=01 one cycle later.
  - tx bytes: 52 0D 01 01 02 03 04 05 06 07 08 E1 9A.
  - done=1, done_id=0.
- Zero payload: REQ1, cmd1=01, data1=0. Check byte = 05, sum of 13 bytes = FF, done_id=1.
- Tie, round-robin: req=11 held continuously across three frames. Grants go REQ0, REQ1, REQ0 (REQ1 drops after its gnt).
  - With FRAME_ARB_FIXED_PRIO_EN: grants go REQ0, REQ0.
- Back-pressure: random tx_ready with 30% high. Byte sequence is identical to the single-frame case; tx_data is stable while tx_valid && !tx_ready.
- Reset mid-frame: assert rst after the 5th byte transfers.
  - Next cycle: tx_valid=0, busy=0, no done.
  - The following req=11 grants REQ0 first.
- Payload change during frame: modify data0 after gnt. Transmitted bytes still match the latched value.

Source files
------------

// File: rtl/frame_pkg.sv
// Frame constants and state encoding shared by the UART frame transmitter and the
// receive-side parser.
package frame_pkg;

    localparam logic [7:0] HEADER = 8'h52;
    localparam logic [7:0] LENGTH = 8'h0D;
    localparam logic [7:0] TAIL   = 8'h9A;

    localparam int PAYLOAD_BYTES = 8;
    localparam int FRAME_BYTES   = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_CMD,
        ST_DATA,
        ST_CHK,
        ST_TAIL
    } frame_state_t;

endpackage

// File: rtl/frame_serializer.sv
// Byte serializer for one 13-byte frame: walks HDR..TAIL on valid/ready handshakes
// and accumulates the running sum used to build the check byte.
module frame_serializer
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [63:0] data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_end
);

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES - 1);

    frame_state_t state, state_next;
    logic [7:0]   sum, sum_next;
    logic [7:0]   tx_data_next;
    logic [2:0]   cnt, cnt_next;
    logic         xfer;

    function automatic logic [7:0] payload_byte(input logic [63:0] d, input logic [2:0] k);
        int lsb;
        lsb = 8 * (PAYLOAD_BYTES - 1 - int'(k));
        return d[lsb +: 8];
    endfunction

    // Check byte makes the 8-bit sum of the whole frame, tail included, equal 0xFF.
    function automatic logic [7:0] check_byte(input logic [7:0] s);
        return 8'hFF - (s + TAIL);
    endfunction

    assign tx_valid = (state != ST_IDLE);
    assign busy     = tx_valid;
    assign xfer     = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_data <= 8'h00;
            sum     <= 8'h00;
            cnt     <= 3'd0;
        end else begin
            state   <= state_next;
            tx_data <= tx_data_next;
            sum     <= sum_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        tx_data_next = tx_data;
        sum_next     = sum;
        cnt_next     = cnt;
        frame_end    = 1'b0;
        if (xfer) begin
            sum_next = sum + tx_data;
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_HDR;
                    tx_data_next = HEADER;
                    sum_next     = 8'h00;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    state_next   = ST_LEN;
                    tx_data_next = LENGTH;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    state_next   = ST_CMD;
                    tx_data_next = cmd;
                end
            end
            ST_CMD: begin
                if (xfer) begin
                    state_next   = ST_DATA;
                    cnt_next     = 3'd0;
                    tx_data_next = payload_byte(data, 3'd0);
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    cnt_next = cnt + 3'd1;
                    if (cnt == LAST_IDX) begin
                        state_next   = ST_CHK;
                        tx_data_next = check_byte(sum_next);
                    end else begin
                        tx_data_next = payload_byte(data, cnt + 3'd1);
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    state_next   = ST_TAIL;
                    tx_data_next = TAIL;
                end
            end
            ST_TAIL: begin
                if (xfer) begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/frame_tx_arbiter.sv
// Two-requester arbiter in front of the frame serializer; round-robin on ties, or
// REQ0 fixed priority when FRAME_ARB_FIXED_PRIO_EN is defined.
module frame_tx_arbiter
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  cmd0,
    input  logic [63:0] data0,
    input  logic [7:0]  cmd1,
    input  logic [63:0] data1,
    output logic [1:0]  gnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        done_id
);

    logic        last;
    logic        winner;
    logic        start;
    logic        frame_end;
    logic [7:0]  cmd_lat;
    logic [63:0] data_lat;

    always_comb begin
        winner = 1'b0;
`ifdef FRAME_ARB_FIXED_PRIO_EN
        winner = ~req[0];
`else
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
`endif
    end

    // Requests are only looked at while the serializer is idle.
    assign start = !busy && (req != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= 2'b00;
            last    <= 1'b1;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            gnt  <= 2'b00;
            done <= frame_end;
            if (start) begin
                gnt  <= winner ? 2'b10 : 2'b01;
                last <= winner;
            end
            if (frame_end) begin
                done_id <= last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            cmd_lat  <= winner ? cmd1 : cmd0;
            data_lat <= winner ? data1 : data0;
        end
    end

    frame_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmd       (cmd_lat),
        .data      (data_lat),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_end (frame_end)
    );

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Randomized bench for frame_tx_arbiter against a frame-level reference model.
module tb_frame_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  cmd0, cmd1;
    logic [63:0] data0, data1;
    logic [1:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, done, done_id;

    frame_tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cmd0     (cmd0),
        .data0    (data0),
        .cmd1     (cmd1),
        .data1    (data1),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit         m_active, m_last, m_owner, exp_done, exp_done_id, mutate;
    logic [1:0] exp_gnt;
    logic [7:0] exp_q[$];
    logic [7:0] frame_log[$];
    int         grant_log[$];
    bit         hold[2];
    int         ready_pct;
    int         xfer_cnt;

    logic [7:0] single_exp [13] = '{8'h52, 8'h0D, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h05, 8'h06, 8'h07, 8'h08, 8'hE1, 8'h9A};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Frame as the receiver sees it: fixed bytes, payload MSB first, check byte
    // chosen so all 13 bytes sum to 0xFF.
    task automatic load_frame(input logic [7:0] c, input logic [63:0] d);
        logic [7:0] b[$];
        logic [7:0] s;
        s = 8'h00;
        b = {8'h52, 8'h0D, c};
        for (int k = 0; k < 8; k++) b.push_back(d[63 - 8*k -: 8]);
        b.push_back(8'h9A);
        foreach (b[i]) s += b[i];
        b.insert(11, 8'hFF - s);
        exp_q = b;
    endtask

    function automatic bit pick(input logic [1:0] r, input bit lst);
`ifdef FRAME_ARB_FIXED_PRIO_EN
        return r[0] ? 1'b0 : 1'b1;
`else
        if (r == 2'b11) return ~lst;
        return r[1];
`endif
    endfunction

    task automatic cycle();
        bit w;
        if (mutate && m_active) begin
            cmd0  = 8'($urandom);
            data0 = {$urandom, $urandom};
            cmd1  = 8'($urandom);
            data1 = {$urandom, $urandom};
        end
        tx_ready = ($urandom_range(99) < ready_pct);
        exp_gnt  = 2'b00;
        exp_done = 1'b0;
        if (m_active) begin
            if (tx_ready) begin
                frame_log.push_back(tx_data);
                void'(exp_q.pop_front());
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    m_active    = 1'b0;
                    exp_done    = 1'b1;
                    exp_done_id = m_owner;
                end
            end
        end else if (req != 2'b00) begin
            w        = pick(req, m_last);
            m_last   = w;
            m_owner  = w;
            exp_gnt  = w ? 2'b10 : 2'b01;
            load_frame(w ? cmd1 : cmd0, w ? data1 : data0);
            m_active = 1'b1;
        end
        @(negedge clk);
        check_eq("gnt", gnt, exp_gnt);
        check_eq("done", done, exp_done);
        if (exp_done) check_eq("done_id", done_id, exp_done_id);
        check_eq("busy", busy, m_active);
        check_eq("tx_valid", tx_valid, m_active);
        if (m_active && tx_valid) check_eq("tx_data", tx_data, exp_q[0]);
        if (gnt != 2'b00) grant_log.push_back(int'(gnt[1]));
        if (gnt[0] && !hold[0]) req[0] = 1'b0;
        if (gnt[1] && !hold[1]) req[1] = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = 2'b00;
        tx_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_done_id", done_id, 1'b0);
        rst         = 1'b0;
        m_active    = 1'b0;
        m_last      = 1'b1;
        exp_q.delete();
        exp_gnt     = 2'b00;
        exp_done    = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((m_active || req != 2'b00 || exp_done) && n < budget);
        check_eq("timeout", n >= budget, 1'b0);
    endtask

    task automatic start_test(input logic [1:0] r, input int pct);
        frame_log.delete();
        grant_log.delete();
        ready_pct = pct;
        req       = r;
    endtask

    initial begin
        logic [7:0] s;
        int first_n;
        cmd0 = 8'h00; data0 = 64'h0; cmd1 = 8'h00; data1 = 64'h0;
        hold[0] = 1'b0; hold[1] = 1'b0; mutate = 1'b0; xfer_cnt = 0;
        do_reset();

        // single frame from REQ0
        cmd0 = 8'h01; data0 = 64'h0102030405060708;
        start_test(2'b01, 100);
        run_until_idle(100);
        check_eq("single_len", frame_log.size(), 13);
        for (int i = 0; i < 13 && i < frame_log.size(); i++) check_eq("single_byte", frame_log[i], single_exp[i]);
        check_eq("single_gnt", grant_log.size() > 0 && grant_log[0] == 0, 1'b1);

        // zero payload from REQ1
        cmd1 = 8'h01; data1 = 64'h0;
        start_test(2'b10, 100);
        run_until_idle(100);
        check_eq("zero_len", frame_log.size(), 13);
        s = 8'h00;
        foreach (frame_log[i]) s += frame_log[i];
        check_eq("zero_sum", s, 8'hFF);
        if (frame_log.size() > 11) check_eq("zero_chk", frame_log[11], 8'h05);
        check_eq("zero_gnt", grant_log.size() > 0 && grant_log[0] == 1, 1'b1);

        // tie with REQ0 held, REQ1 drops after its grant
        hold[0] = 1'b1;
        start_test(2'b11, 100);
        for (int n = 0; n < 200 && grant_log.size() < 3; n++) cycle();
        req[0] = 1'b0; hold[0] = 1'b0;
        run_until_idle(200);
        check_eq("tie_n", grant_log.size() >= 3, 1'b1);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
`ifdef FRAME_ARB_FIXED_PRIO_EN
            check_eq("tie_order", grant_log[i], 0);
`else
            check_eq("tie_order", grant_log[i], (i == 1) ? 1 : 0);
`endif
        end

        // back-pressure, same frame as the single case
        cmd0 = 8'h01; data0 = 64'h0102030405060708;
        start_test(2'b01, 30);
        run_until_idle(600);
        check_eq("bp_len", frame_log.size(), 13);
        for (int i = 0; i < 13 && i < frame_log.size(); i++) check_eq("bp_byte", frame_log[i], single_exp[i]);

        // reset after the fifth byte
        xfer_cnt = 0;
        start_test(2'b10, 100);
        for (int n = 0; n < 100 && xfer_cnt < 5; n++) cycle();
        do_reset();
        start_test(2'b11, 100);
        run_until_idle(200);
        check_eq("rst_tie_n", grant_log.size(), 2);
        if (grant_log.size() > 0) check_eq("rst_tie_first", grant_log[0], 0);

        // payload changes during frame, then random traffic
        mutate = 1'b1;
        cmd0 = 8'hA5; data0 = {$urandom, $urandom};
        start_test(2'b01, 60);
        run_until_idle(400);
        check_eq("mut_len", frame_log.size(), 13);
        for (int f = 0; f < 10; f++) begin
            cmd0 = 8'($urandom); data0 = {$urandom, $urandom};
            cmd1 = 8'($urandom); data1 = {$urandom, $urandom};
            first_n = $urandom_range(30, 100);
            start_test(2'($urandom_range(1, 3)), first_n);
            run_until_idle(1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
